// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous font ROM among several drawing stages.
// Each access returns its glyph row to the issuing requester a fixed ROM_LATENCY+1 edges after grant.
module font_rom_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]  data_q;
    logic [NUM_REQ-1:0] tag_q [ROM_LATENCY+1];

    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [PTR_W-1:0]   win;
    int unsigned        idx;
    int unsigned        nxt;

    // A requester granted on the previous edge must sit out one edge.
    assign elig = req & ~gnt_q;

    always_comb begin
        found  = 1'b0;
        win    = '0;
        idx    = 0;
        nxt    = 0;
        gnt_d  = '0;
        addr_d = addr_q;
        ptr_d  = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        if (found) begin
            gnt_d[win] = 1'b1;
            addr_d     = req_addr[int'(win)*ADDR_W +: ADDR_W];
            nxt        = int'(win) + 1;
            if (nxt == NUM_REQ) begin
                nxt = 0;
            end
            ptr_d = PTR_W'(nxt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q  <= '0;
            addr_q <= '0;
            ptr_q  <= '0;
        end else begin
            gnt_q  <= gnt_d;
            addr_q <= addr_d;
            ptr_q  <= ptr_d;
        end
    end

    // Tag pipeline: the last stage is the registered rsp_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s <= ROM_LATENCY; s++) begin
                tag_q[s] <= '0;
            end
            data_q <= '0;
        end else begin
            tag_q[0] <= gnt_q;
            for (int unsigned s = 1; s <= ROM_LATENCY; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            if (|tag_q[ROM_LATENCY-1]) begin
                data_q <= rom_data;
            end
        end
    end

    assign gnt       = gnt_q;
    assign rom_addr  = addr_q;
    assign rsp_valid = tag_q[ROM_LATENCY];
    assign rsp_data  = data_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter: stimulus pushes expected responses, a monitor pops and checks them.
module tb_font_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data = '0;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [NUM_REQ-1:0] v;
        logic [DATA_W-1:0]  d;
        int                 t;
    } exp_t;

    exp_t q[$];
    exp_t e;

    font_rom_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ROM_LATENCY(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data)
    );

    always #5 clk = ~clk;

    // Font ROM stand-in, one edge of latency.
    function automatic logic [7:0] rom_f(input logic [10:0] a);
        if (a == 11'h050) return 8'h3C;
        return a[7:0] + 8'h11;
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rsp_valid pulse must match the oldest pending expectation, on its cycle.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].t < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_missing: got none expected %0h/%0h at cycle %0d", q[0].v, q[0].d,
                     q[0].t);
            void'(q.pop_front());
        end
        if (rsp_valid != '0) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
                e = q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
                chk("rsp_data", 32'(rsp_data), 32'(e.d));
                chk("rsp_cycle", 32'(cyc), 32'(e.t));
            end
        end
    end

    // Check the grant of the preceding edge, queue its expected response, set next request.
    task automatic step(input logic [3:0] eg, input logic [10:0] ea, input logic [7:0] ed,
                        input logic [3:0] next_req);
        exp_t x;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rom_addr", 32'(rom_addr), 32'(ea));
        if (eg != 4'b0000) begin
            x.v = eg;
            x.d = ed;
            x.t = cyc + 2;
            q.push_back(x);
        end
        req = next_req;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_addr = {11'h070, 11'h050, 11'h020, 11'h010};
        req      = 4'b1111;
        rst      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        rst = 1'b1;

        // Round robin from pointer 0, then skip/wrap cases.
        step(4'b0001, 11'h010, 8'h21, 4'b1111);
        step(4'b0010, 11'h020, 8'h31, 4'b1111);
        step(4'b0100, 11'h050, 8'h3C, 4'b1111);
        step(4'b1000, 11'h070, 8'h81, 4'b1111);
        step(4'b0001, 11'h010, 8'h21, 4'b1111);
        step(4'b0010, 11'h020, 8'h31, 4'b1111);
        step(4'b0100, 11'h050, 8'h3C, 4'b1111);
        step(4'b1000, 11'h070, 8'h81, 4'b0101);
        step(4'b0001, 11'h010, 8'h21, 4'b0101);
        step(4'b0100, 11'h050, 8'h3C, 4'b0010);
        step(4'b0010, 11'h020, 8'h31, 4'b0001);
        step(4'b0001, 11'h010, 8'h21, 4'b0000);
        step(4'b0000, 11'h010, 8'h00, 4'b0000);
        step(4'b0000, 11'h010, 8'h00, 4'b0000);
        step(4'b0000, 11'h010, 8'h00, 4'b0100);

        // Lone requester: granted every second edge.
        step(4'b0100, 11'h050, 8'h3C, 4'b0100);
        step(4'b0000, 11'h050, 8'h00, 4'b0100);
        step(4'b0100, 11'h050, 8'h3C, 4'b0100);
        step(4'b0000, 11'h050, 8'h00, 4'b0000);
        step(4'b0000, 11'h050, 8'h00, 4'b0000);
        step(4'b0000, 11'h050, 8'h00, 4'b0000);
        req_addr[1*ADDR_W +: ADDR_W] = 11'h123;
        step(4'b0000, 11'h050, 8'h00, 4'b0010);

        // Idle hold after one grant to requester 1.
        step(4'b0010, 11'h123, 8'h34, 4'b0000);
        repeat (5) step(4'b0000, 11'h123, 8'h00, 4'b0000);
        chk("rsp_data_hold", 32'(rsp_data), 32'h34);
        req_addr[1*ADDR_W +: ADDR_W] = 11'h020;
        req = 4'b0100;

        // Reset while an access is in flight: its response must never appear.
        @(negedge clk);
        chk("mid_gnt", 32'(gnt), 32'h4);
        chk("mid_rom_addr", 32'(rom_addr), 32'h050);
        @(negedge clk);
        chk("mid_gnt_gap", 32'(gnt), 32'h0);
        rst = 1'b0;
        req = 4'b1111;
        repeat (2) @(negedge clk);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_rom_addr", 32'(rom_addr), 32'h0);
        rst = 1'b1;
        step(4'b0001, 11'h010, 8'h21, 4'b1111);
        step(4'b0010, 11'h020, 8'h31, 4'b0000);
        repeat (5) step(4'b0000, 11'h020, 8'h00, 4'b0000);

        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares the single synchronous font ROM (11-bit address, 8-bit glyph row) among several character-drawing stages of the VGA pipeline, e.g. centre number, board-size label and score text.
- Uses round-robin request/grant arbitration and issues at most one ROM access per clock.
- Routes each returned glyph row back to the requester that issued it, with a fixed, known latency so drawing stages can pre-fetch.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 11, font ROM address width.
- DATA_W, 8, font ROM data width (one glyph row).
- ROM_LATENCY, 1, clock edges from rom_addr change to valid rom_data (1..3).

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, asynchronous active-low reset.
- req, input, NUM_REQ, per-requester access request (level).
- req_addr, input, NUM_REQ*ADDR_W, flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- gnt, output, NUM_REQ, one-hot registered grant pulse.
- rom_addr, output, ADDR_W, address to font ROM.
- rom_data, input, DATA_W, glyph row from font ROM.
- rsp_valid, output, NUM_REQ, one-hot flag that rsp_data belongs to requester i.
- rsp_data, output, DATA_W, registered glyph row.

Behaviour:
- Reset: rst low asynchronously clears gnt=0, rom_addr=0, rsp_valid=0, rsp_data=0, round-robin pointer=0 and the tag pipeline.
  - Reset mid-operation discards all in-flight accesses; no rsp_valid is issued for them after release.
  - First arbitration happens on the first rising edge with rst high.
- Eligibility: requester i is eligible at a rising edge if req[i]=1 and gnt[i]=0 at that edge. A requester granted on edge k cannot be granted on edge k+1.
- Arbitration on each rising edge:
  - Search eligible requesters starting at the pointer, ascending modulo NUM_REQ; first hit is winner w.
  - On a winner: gnt<=onehot(w), rom_addr<=req_addr[w], pointer<=(w+1) mod NUM_REQ.
  - No eligible requester: gnt<=0, rom_addr holds its value, pointer unchanged, no access is tagged.
- Handshake:
  - Requester holds req and req_addr stable until it sees gnt[i]=1.
  - During the gnt cycle it may drop req, or present the next address with req still high; that next request is served no earlier than the following edge.
- Tag pipeline: shift register of ROM_LATENCY+1 stages, each NUM_REQ bits wide, loaded with the gnt value each edge.
- Response:
  - Access granted on edge k produces rsp_valid=onehot(w) and rsp_data=rom_data (registered) after edge k+ROM_LATENCY+1. Default total latency is 2 edges.
  - rsp_valid is high for exactly one cycle per grant.
  - rsp_data holds its last value when rsp_valid=0.
- Throughput: one grant per cycle sustained. Back-to-back grants to different requesters give back-to-back responses in grant order.
- Fairness: with all NUM_REQ requesting continuously, each requester is granted exactly once every NUM_REQ cycles. A single lone requester holding req high is granted every second cycle.
- Simultaneous events: multiple new requests on one edge are resolved only by the pointer order; the pointer wraps from NUM_REQ-1 to 0.
- Blanking: requests are allowed at any time; the block ignores hblnk/vblnk.

Test Plan:
- Reset: hold rst=0 with req=4'b1111 → gnt, rsp_valid, rom_addr, rsp_data all 0. After release, first grant gnt=4'b0001 on first edge.
- Single requester: req[2]=1, req_addr[2]=11'h050 held, rom returns 8'h3C at 11'h050 → rom_addr=11'h050 after grant edge k. gnt toggles 0100/0000 on alternate cycles. rsp_valid=4'b0100 with rsp_data=8'h3C after edge k+2.
- Round robin: req=4'b1111 continuously from pointer 0 → gnt sequence 0001, 0010, 0100, 1000, 0001. Responses follow the same order two edges later.
- Pointer skip and wrap: after grant to 3, req=4'b0101 → gnt=0001 then 0100. After grant to 1, req=4'b0001 → gnt=0001.
- Idle hold: grant to requester 1 with address 11'h123, then req=0 for 5 cycles → rom_addr stays 11'h123, gnt=0, exactly one rsp_valid pulse is seen.
- Reset mid-flight: assert rst=0 one cycle after a grant → no rsp_valid for that access. The first grant after release goes to requester 0 if it is requesting.
